// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush control: operand hazards, MDU busy sequencing; stall/E_clr are combinational.
// Define PIPE_PERF_CNT_EN to build the stall_cycles performance counter; otherwise it reads 0.
module pipe_stall_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        Req,
  input  logic [4:0]  D_rs_addr,
  input  logic [4:0]  D_rt_addr,
  input  logic [1:0]  D_Tuse_rs,
  input  logic [1:0]  D_Tuse_rt,
  input  logic [4:0]  E_A3,
  input  logic [1:0]  E_Tnew,
  input  logic [4:0]  M_A3,
  input  logic [1:0]  M_Tnew,
  input  logic        D_is_md,
  input  logic        E_md_mul,
  input  logic        E_md_div,
  output logic        stall,
  output logic        E_clr,
  output logic        md_busy,
  output logic        md_done,
  output logic [3:0]  busy_cnt,
  output logic [31:0] stall_cycles
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_MUL = 2'd1, S_DIV = 2'd2} md_state_t;

  md_state_t  r_state;
  md_state_t  w_state_nxt;
  logic [3:0] r_busy_cnt;
  logic [3:0] w_busy_cnt_nxt;
  logic       w_rs_haz;
  logic       w_rt_haz;
  logic       w_md_stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_busy_cnt <= 4'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_busy_cnt <= w_busy_cnt_nxt;
    end
  end

  // Req only blocks a start; an operation already in flight always runs to completion.
  always_comb begin
    w_state_nxt    = r_state;
    w_busy_cnt_nxt = r_busy_cnt;
    case (r_state)
      S_IDLE: begin
        if (!Req && E_md_mul) begin
          w_state_nxt    = S_MUL;
          w_busy_cnt_nxt = 4'd5;
        end else if (!Req && E_md_div) begin
          w_state_nxt    = S_DIV;
          w_busy_cnt_nxt = 4'd10;
        end
      end
      S_MUL, S_DIV: begin
        if (r_busy_cnt == 4'd1) begin
          w_state_nxt    = S_IDLE;
          w_busy_cnt_nxt = 4'd0;
        end else begin
          w_busy_cnt_nxt = r_busy_cnt - 4'd1;
        end
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_busy_cnt_nxt = 4'd0;
      end
    endcase
  end

  always_comb begin
    md_busy  = (r_state == S_MUL) || (r_state == S_DIV);
    md_done  = md_busy && (r_busy_cnt == 4'd1);
    busy_cnt = r_busy_cnt;
  end

  always_comb begin
    w_rs_haz = (D_rs_addr != 5'd0) &&
               (((E_A3 == D_rs_addr) && (E_Tnew > D_Tuse_rs)) ||
                ((M_A3 == D_rs_addr) && (M_Tnew > D_Tuse_rs)));
    w_rt_haz = (D_rt_addr != 5'd0) &&
               (((E_A3 == D_rt_addr) && (E_Tnew > D_Tuse_rt)) ||
                ((M_A3 == D_rt_addr) && (M_Tnew > D_Tuse_rt)));
    // Under reset the MDU is treated as idle even before the first edge clears the state.
    w_md_stall = D_is_md && ((md_busy && !reset) || E_md_mul || E_md_div);
    stall      = (w_rs_haz || w_rt_haz || w_md_stall) && !Req;
    E_clr      = stall;
  end

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] r_stall_cycles;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cycles <= 32'd0;
    end else if (stall) begin
      r_stall_cycles <= r_stall_cycles + 32'd1;
    end
  end

  assign stall_cycles = r_stall_cycles;
`else
  assign stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: directed scenarios with literal expectations plus randomized traffic
// compared each cycle against a remaining-cycles model of the MDU and the hazard rules.
module tb_pipe_stall_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        Req;
  logic [4:0]  D_rs_addr, D_rt_addr, E_A3, M_A3;
  logic [1:0]  D_Tuse_rs, D_Tuse_rt, E_Tnew, M_Tnew;
  logic        D_is_md, E_md_mul, E_md_div;
  logic        stall, E_clr, md_busy, md_done;
  logic [3:0]  busy_cnt;
  logic [31:0] stall_cycles;

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  int          m_left = 0;
  bit [31:0]   m_perf = 0;

  always #5 clk = ~clk;

  pipe_stall_ctrl dut (
    .clk(clk), .reset(reset), .Req(Req),
    .D_rs_addr(D_rs_addr), .D_rt_addr(D_rt_addr),
    .D_Tuse_rs(D_Tuse_rs), .D_Tuse_rt(D_Tuse_rt),
    .E_A3(E_A3), .E_Tnew(E_Tnew), .M_A3(M_A3), .M_Tnew(M_Tnew),
    .D_is_md(D_is_md), .E_md_mul(E_md_mul), .E_md_div(E_md_div),
    .stall(stall), .E_clr(E_clr), .md_busy(md_busy), .md_done(md_done),
    .busy_cnt(busy_cnt), .stall_cycles(stall_cycles)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit hazard(input logic [4:0] a, input logic [1:0] tuse);
    int t;
    t = tuse;
    return (a != 0) && (((E_A3 == a) && (int'(E_Tnew) > t)) || ((M_A3 == a) && (int'(M_Tnew) > t)));
  endfunction

  function automatic bit exp_stall();
    bit busy;
    busy = !reset && (m_left > 0);
    return (hazard(D_rs_addr, D_Tuse_rs) || hazard(D_rt_addr, D_Tuse_rt) ||
            (D_is_md && (busy || E_md_mul || E_md_div))) && !Req;
  endfunction

  function automatic logic [31:0] exp_perf();
`ifdef PIPE_PERF_CNT_EN
    return m_perf;
`else
    return 32'd0;
`endif
  endfunction

  // Model: m_left counts the cycles an MDU operation still occupies the unit.
  always @(posedge clk) begin
    if (reset) begin
      m_left = 0;
      m_perf = 0;
    end else begin
      if (exp_stall()) m_perf = m_perf + 1;
      if (m_left > 0) m_left = m_left - 1;
      else if (!Req && E_md_mul) m_left = 5;
      else if (!Req && E_md_div) m_left = 10;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_stall",    {31'd0, stall},   {31'd0, exp_stall()});
      chk("m_eclr",     {31'd0, E_clr},   {31'd0, exp_stall()});
      chk("m_busy",     {31'd0, md_busy}, (m_left > 0) ? 32'd1 : 32'd0);
      chk("m_done",     {31'd0, md_done}, (m_left == 1) ? 32'd1 : 32'd0);
      chk("m_cnt",      {28'd0, busy_cnt}, m_left);
      chk("m_perf",     stall_cycles, exp_perf());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    Req = 0; D_rs_addr = 0; D_rt_addr = 0; D_Tuse_rs = 3; D_Tuse_rt = 3;
    E_A3 = 0; E_Tnew = 0; M_A3 = 0; M_Tnew = 0;
    D_is_md = 0; E_md_mul = 0; E_md_div = 0;
  endtask

  initial begin
    reset = 1;
    clear_inputs();
    tick();
    tick();
    chk_en = 1;
    neg();
    chk("rst_busy",  {31'd0, md_busy}, 0);
    chk("rst_cnt",   {28'd0, busy_cnt}, 0);
    chk("rst_perf",  stall_cycles, 0);
    // Under reset, stall still tracks hazards from the inputs.
    E_A3 = 5; E_Tnew = 2; D_rs_addr = 5; D_Tuse_rs = 1;
    neg();
    chk("rst_stall", {31'd0, stall}, 1);
    reset = 0;
    clear_inputs();
    tick();

    E_A3 = 5; E_Tnew = 2; D_rs_addr = 5; D_Tuse_rs = 1;
    neg();
    chk("e_haz_stall", {31'd0, stall}, 1);
    chk("e_haz_eclr",  {31'd0, E_clr}, 1);
    D_rs_addr = 0;
    neg();
    chk("r0_no_stall", {31'd0, stall}, 0);
    clear_inputs();
    M_A3 = 8; M_Tnew = 1; D_rt_addr = 8; D_Tuse_rt = 0; Req = 1;
    neg();
    chk("m_haz_req", {31'd0, stall}, 0);
    Req = 0;
    neg();
    chk("m_haz", {31'd0, stall}, 1);
    clear_inputs();
    tick();

    // Divide: 10 busy cycles, D-stage md instruction stalls throughout.
    E_md_div = 1;
    tick();
    E_md_div = 0; D_is_md = 1;
    for (int k = 10; k >= 1; k--) begin
      neg();
      chk("div_cnt",   {28'd0, busy_cnt}, k);
      chk("div_done",  {31'd0, md_done}, (k == 1) ? 1 : 0);
      chk("div_stall", {31'd0, stall}, 1);
      tick();
    end
    neg();
    chk("div_end_cnt",  {28'd0, busy_cnt}, 0);
    chk("div_end_busy", {31'd0, md_busy}, 0);
    D_is_md = 0;

    E_md_mul = 1; Req = 1;
    tick();
    E_md_mul = 0; Req = 0;
    neg();
    chk("mul_req_cnt",  {28'd0, busy_cnt}, 0);
    chk("mul_req_busy", {31'd0, md_busy}, 0);

    E_md_mul = 1;
    tick();
    E_md_mul = 0;
    neg(); chk("mul_c5", {28'd0, busy_cnt}, 5);
    tick(); tick();
    Req = 1;
    neg(); chk("mul_c3", {28'd0, busy_cnt}, 3);
    tick();
    Req = 0;
    neg(); chk("mul_c2", {28'd0, busy_cnt}, 2);
    tick();
    neg(); chk("mul_done", {31'd0, md_done}, 1);
    tick();
    neg(); chk("mul_c0", {28'd0, busy_cnt}, 0);

    E_md_div = 1;
    tick();
    E_md_div = 0;
    tick(); tick(); tick(); tick();
    neg(); chk("div_c6", {28'd0, busy_cnt}, 6);
    reset = 1;
    tick();
    reset = 0;
    neg();
    chk("div_rst_cnt",  {28'd0, busy_cnt}, 0);
    chk("div_rst_busy", {31'd0, md_busy}, 0);

    reset = 1;
    tick();
    reset = 0;
    E_A3 = 5; E_Tnew = 2; D_rs_addr = 5; D_Tuse_rs = 1;
    repeat (7) tick();
    clear_inputs();
    neg();
`ifdef PIPE_PERF_CNT_EN
    chk("perf7", stall_cycles, 7);
`else
    chk("perf7", stall_cycles, 0);
`endif
    tick();

    for (int c = 0; c < 3000; c++) begin
      reset     = ($urandom_range(0, 199) == 0);
      Req       = ($urandom_range(0, 9) == 0);
      D_rs_addr = 5'($urandom_range(0, 3));
      D_rt_addr = 5'($urandom_range(0, 3));
      D_Tuse_rs = 2'($urandom_range(0, 3));
      D_Tuse_rt = 2'($urandom_range(0, 3));
      E_A3      = 5'($urandom_range(0, 3));
      M_A3      = 5'($urandom_range(0, 3));
      E_Tnew    = 2'($urandom_range(0, 3));
      M_Tnew    = 2'($urandom_range(0, 3));
      D_is_md   = ($urandom_range(0, 2) == 0);
      E_md_mul  = ($urandom_range(0, 11) == 0);
      E_md_div  = ($urandom_range(0, 11) == 0);
      tick();
    end

    chk_en = 0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_stall_ctrl.md
PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port Req, input, 1 bit: exception/interrupt taken this cycle; all pipeline registers flush.
REQ-004 SHALL have ports D_rs_addr and D_rt_addr, input, 5 bits each: D-stage source registers.
REQ-005 SHALL have ports D_Tuse_rs and D_Tuse_rt, input, 2 bits each: cycles until operand is needed; 3 means unused.
REQ-006 SHALL have ports E_A3 (input, 5 bits) and E_Tnew (input, 2 bits): E-stage destination and cycles until its result is ready.
REQ-007 SHALL have ports M_A3 (input, 5 bits) and M_Tnew (input, 2 bits): same meaning for the M stage.
REQ-008 SHALL have port D_is_md, input, 1 bit: D instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo.
REQ-009 SHALL have ports E_md_mul and E_md_div, input, 1 bit each: E instruction starts a multiply / divide.
REQ-010 SHALL have port stall, output, 1 bit: freeze PC, F and D registers.
REQ-011 SHALL have port E_clr, output, 1 bit: insert a bubble into the E register.
REQ-012 SHALL have ports md_busy (output, 1 bit), md_done (output, 1 bit) and busy_cnt (output, 4 bits): MDU sequencing status.
REQ-013 SHALL have port stall_cycles, output, 32 bits: performance counter (see Configuration).

Function
REQ-014 SHALL assert rs hazard when D_rs_addr!=0 and either (E_A3==D_rs_addr and E_Tnew>D_Tuse_rs) or (M_A3==D_rs_addr and M_Tnew>D_Tuse_rs); the rt hazard SHALL be computed identically.
REQ-015 SHALL assert md_stall when D_is_md and (md_busy or E_md_mul or E_md_div).
REQ-016 SHALL drive stall = (rs hazard or rt hazard or md_stall) and not Req, combinationally.
REQ-017 SHALL drive E_clr equal to stall.
REQ-018 SHALL implement MDU FSM states IDLE, MUL, DIV; md_busy=1 in MUL and DIV.
REQ-019 In IDLE, SHALL go to MUL with busy_cnt=5 when E_md_mul and not Req, or to DIV with busy_cnt=10 when E_md_div and not Req; E_md_mul has priority if both are asserted.
REQ-020 In MUL or DIV, SHALL decrement busy_cnt each cycle, and SHALL return to IDLE with busy_cnt=0 on the edge where busy_cnt==1.
REQ-021 SHALL drive md_done=1 combinationally exactly while in MUL or DIV with busy_cnt==1.
REQ-022 SHALL ignore Req while in MUL or DIV: a started operation always completes.
REQ-023 SHALL ignore E_md_mul and E_md_div while not in IDLE.
REQ-024 SHALL suppress a start when Req coincides with E_md_mul or E_md_div; the FSM stays in IDLE.

Reset
REQ-025 On reset, SHALL enter IDLE with busy_cnt=0, md_busy=0, md_done=0 and stall_cycles=0, including mid-operation; reset SHALL override Req and starts.
REQ-026 While reset is asserted, stall and E_clr SHALL follow REQ-016 from the current inputs with md_busy=0.

Configuration
REQ-027 With PIPE_PERF_CNT_EN defined, stall_cycles SHALL increment by 1 on every edge where stall=1 and reset=0, wrapping from 0xFFFFFFFF to 0.
REQ-028 Without PIPE_PERF_CNT_EN, stall_cycles SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-029 E_A3=5, E_Tnew=2, D_rs_addr=5, D_Tuse_rs=1 -> stall=1, E_clr=1; the same with D_rs_addr=0 -> stall=0.
REQ-030 M_A3=8, M_Tnew=1, D_rt_addr=8, D_Tuse_rt=0 with Req=1 -> stall=0; with Req=0 -> stall=1.
REQ-031 E_md_div pulse for 1 cycle -> busy_cnt sequence 10,9,...,1,0; md_done high for 1 cycle when busy_cnt=1; D_is_md=1 stalls throughout that period.
REQ-032 E_md_mul=1 and Req=1 in the same cycle -> FSM stays IDLE, busy_cnt=0; Req=1 at busy_cnt=3 in MUL -> counting continues to 0.
REQ-033 Reset asserted at busy_cnt=6 in DIV -> next cycle IDLE, busy_cnt=0, md_busy=0.
REQ-034 With PIPE_PERF_CNT_EN, 7 stall cycles after reset -> stall_cycles=7; without the macro -> stall_cycles=0.
